// File: rtl/opcode_dispatcher_if.sv
// ---------------------------------------------------------------------------
// opcode_dispatcher_if
// Purpose : groups the host-side write port, the compiler handshake and the
//           dispatcher status outputs into a single bundle.
// Signals :
//   OpcodeIn [7:0]  host -> dispatcher opcode word
//   Push            host write strobe
//   Ready           compiler status level (1 = idle)
//   Opcode   [7:0]  opcode presented to the compiler
//   Start           one-cycle request to the compiler
//   Full/Empty      queue status
//   Level    [2:0]  queue occupancy 0..4
//   Busy            dispatcher FSM not idle
//   IssueCount[7:0] Start pulses issued, modulo 256
//   Timeout         one-cycle watchdog expiry pulse
//   Illegal         one-cycle pulse when an opcode is filtered out
// Modports: master = host/compiler side, slave = dispatcher.
// ---------------------------------------------------------------------------
interface opcode_dispatcher_if;
  logic [7:0] OpcodeIn;
  logic       Push;
  logic       Ready;
  logic [7:0] Opcode;
  logic       Start;
  logic       Full;
  logic       Empty;
  logic [2:0] Level;
  logic       Busy;
  logic [7:0] IssueCount;
  logic       Timeout;
  logic       Illegal;

  modport master (
    output OpcodeIn, Push, Ready,
    input  Opcode, Start, Full, Empty, Level, Busy, IssueCount, Timeout, Illegal
  );

  modport slave (
    input  OpcodeIn, Push, Ready,
    output Opcode, Start, Full, Empty, Level, Busy, IssueCount, Timeout, Illegal
  );
endinterface

// File: rtl/opcode_dispatcher.sv
// ---------------------------------------------------------------------------
// opcode_dispatcher
// Purpose : buffers host opcodes in a 4-entry FIFO and hands them one at a
//           time to a compiler using a Start / Ready handshake, with a
//           watchdog on the compiler's acknowledge.
// Ports   :
//   Clk  - sole clock, rising edge
//   Rst  - asynchronous active-low reset
//   bus  - opcode_dispatcher_if.slave (host write port, compiler handshake,
//          queue/FSM status)
// Option  : define OPCODE_FILTER_EN to discard opcodes outside the legal set
//           instead of issuing them (Illegal pulses for each discard).
//           Without the macro every opcode is issued and Illegal stays 0.
// ---------------------------------------------------------------------------
module opcode_dispatcher (
  input  logic                Clk,
  input  logic                Rst,
  opcode_dispatcher_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] fifo_q [4];
  // Pointers carry a wrap bit in [2] so full and empty can be told apart.
  logic [2:0] wr_ptr_q, wr_ptr_d;
  logic [2:0] rd_ptr_q, rd_ptr_d;
  logic [7:0] opcode_q, opcode_d;
  logic [7:0] issue_count_q, issue_count_d;
  logic [3:0] wdog_q, wdog_d;
  logic       timeout_q, timeout_d;
  logic       illegal_q, illegal_d;

  logic       full;
  logic       empty;
  logic       pop;
  logic       push_ok;
  logic [7:0] head;
  logic       head_legal;

  assign full  = (wr_ptr_q[1:0] == rd_ptr_q[1:0]) && (wr_ptr_q[2] != rd_ptr_q[2]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign head  = fifo_q[rd_ptr_q[1:0]];

  // A push into a full queue still lands if the head leaves on the same edge.
  assign push_ok = bus.Push && (!full || pop);

`ifdef OPCODE_FILTER_EN
  always_comb begin
    head_legal = (head <= 8'h19)
              || ((head >= 8'h40) && (head <= 8'h47))
              || (head == 8'h49) || (head == 8'h4A)
              || (head == 8'h80) || (head == 8'h81);
  end
`else
  assign head_legal = 1'b1;
`endif

  // FSM next state and registered outputs.
  always_comb begin
    state_d       = state_q;
    opcode_d      = opcode_q;
    issue_count_d = issue_count_q;
    wdog_d        = wdog_q;
    timeout_d     = 1'b0;
    illegal_d     = 1'b0;
    pop           = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (head_legal) begin
            opcode_d = head;
            state_d  = ISSUE;
          end else begin
            // Discarded head: nothing is issued, FSM stays idle.
            illegal_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        issue_count_d = issue_count_q + 8'd1;
        wdog_d        = 4'd0;
        state_d       = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!bus.Ready) begin
          state_d = WAIT_DONE;
        end else if (wdog_q == 4'hF) begin
          // 16th consecutive edge without the compiler going busy.
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          wdog_d = wdog_q + 4'd1;
        end
      end
      WAIT_DONE: begin
        if (bus.Ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + {2'b00, push_ok};
    rd_ptr_d = rd_ptr_q + {2'b00, pop};
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q       <= IDLE;
      wr_ptr_q      <= 3'd0;
      rd_ptr_q      <= 3'd0;
      opcode_q      <= 8'h00;
      issue_count_q <= 8'h00;
      wdog_q        <= 4'd0;
      timeout_q     <= 1'b0;
      illegal_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      opcode_q      <= opcode_d;
      issue_count_q <= issue_count_d;
      wdog_q        <= wdog_d;
      timeout_q     <= timeout_d;
      illegal_q     <= illegal_d;
    end
  end

  // Queue storage needs no reset: the pointers define which entries are valid.
  always_ff @(posedge Clk) begin
    if (push_ok) begin
      fifo_q[wr_ptr_q[1:0]] <= bus.OpcodeIn;
    end
  end

  assign bus.Opcode     = opcode_q;
  assign bus.Start      = (state_q == ISSUE);
  assign bus.Full       = full;
  assign bus.Empty      = empty;
  assign bus.Level      = wr_ptr_q - rd_ptr_q;
  assign bus.Busy       = (state_q != IDLE);
  assign bus.IssueCount = issue_count_q;
  assign bus.Timeout    = timeout_q;
  // Without the filter illegal_d is constant 0, so this is a tied-off 0.
  assign bus.Illegal    = illegal_q;

endmodule

// File: doc/opcode_dispatcher.md
OPCODE_DISPATCHER -- requirements
Module: opcode_dispatcher

Interface
REQ-001 Clk  input  1  sole clock; all state updates on rising edge.
REQ-002 Rst  input  1  asynchronous, active-low reset (Rst=0 resets immediately, independent of Clk).
REQ-003 OpcodeIn  input  8  opcode word from host.
REQ-004 Push  input  1  host write strobe; sampled each rising edge.
REQ-005 Ready  input  1  compiler status level; 1 = compiler idle, 0 = sequence in progress.
REQ-006 Opcode  output  8  opcode presented to compiler; held stable from pop until return to IDLE.
REQ-007 Start  output  1  one-cycle request to compiler.
REQ-008 Full / Empty  output  1 each  queue status, combinational from pointers.
REQ-009 Level  output  3  queue occupancy, 0..4.
REQ-010 Busy  output  1  1 whenever FSM is not IDLE.
REQ-011 IssueCount  output  8  number of Start pulses issued, modulo 256.
REQ-012 Timeout  output  1  one-cycle pulse on watchdog expiry.
REQ-013 Illegal  output  1  one-cycle pulse when an opcode is discarded by the filter (REQ-030).

Function
REQ-014 Queue SHALL be a 4-entry FIFO: 2-bit read/write pointers plus wrap bit; Full = pointers equal with wrap bits differing; Empty = pointers and wrap bits equal.
REQ-015 Push with Full=0 SHALL write OpcodeIn at the write pointer on that edge.
REQ-016 Push with Full=1 SHALL be accepted only when a pop occurs on the same edge; otherwise it is dropped and queue contents are unchanged.
REQ-017 Push and pop on the same edge with 0<Level<4 SHALL leave Level unchanged; entry order SHALL be preserved.
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-019 IDLE: on an edge with Empty=0, pop the head into the Opcode register and go to ISSUE; otherwise stay in IDLE.
REQ-020 ISSUE: Start=1 for exactly this one cycle; increment IssueCount; go to WAIT_BUSY.
REQ-021 WAIT_BUSY: on an edge with Ready=0, go to WAIT_DONE; a 4-bit watchdog counts cycles spent in this state.
REQ-022 Watchdog: on the 16th consecutive WAIT_BUSY edge with Ready=1, pulse Timeout for one cycle and go to IDLE; the watchdog clears on every entry to WAIT_BUSY.
REQ-023 WAIT_DONE: on an edge with Ready=1, go to IDLE; no timeout applies in this state.
REQ-024 Latency: Push sampled at edge k into an empty queue with FSM in IDLE gives pop at edge k+1 and Start=1 in the cycle between edges k+1 and k+2.
REQ-025 Back-to-back opcodes: after Ready returns to 1, there is one IDLE cycle before the next pop.
REQ-026 Start SHALL never be 1 outside ISSUE; Opcode SHALL not change outside an IDLE->ISSUE transition.

Reset
REQ-027 Rst=0 SHALL clear both pointers and the wrap bit and set the FSM to IDLE, Opcode=8'h00, Start=0, IssueCount=0, watchdog=0, Timeout=0, Illegal=0; giving Empty=1, Full=0, Level=0, Busy=0.
REQ-028 Rst asserted mid-sequence (any state) SHALL abort immediately; queued opcodes are lost; no Start is issued during reset.
REQ-029 After Rst deasserts, the first edge SHALL behave as IDLE with an empty queue.

Configuration
REQ-030 Macro OPCODE_FILTER_EN: when defined, IDLE SHALL check the head opcode against the legal set {8'h00-8'h19, 8'h40-8'h47, 8'h49, 8'h4A, 8'h80, 8'h81}. An illegal head is popped and discarded, Illegal pulses for one cycle, the FSM stays in IDLE, and IssueCount is unchanged.
REQ-031 When OPCODE_FILTER_EN is undefined, every opcode SHALL be issued and Illegal SHALL be tied to 0.

Verification
REQ-032 Reset, then push 8'h4A with Ready=1; Ready drops 1 cycle after Start and rises 3 cycles later -> Start pulses once with Opcode=8'h4A, IssueCount=1, Busy falls the edge after Ready=1.
REQ-033 Push 8'h41, 8'h10, 8'h00, 8'h81, 8'h40 on consecutive edges while the FSM is held in WAIT_DONE -> Full asserts after the 4th push, the 5th push is dropped, and 4 Starts issue in order 41,10,00,81.
REQ-034 Push 8'h10 with Ready held at 1 -> Timeout pulses on the 16th WAIT_BUSY edge, FSM returns to IDLE, IssueCount=1.
REQ-035 Hold Full=1 and push while a pop occurs on the same edge -> push accepted, Level stays 4.
REQ-036 Assert Rst during WAIT_DONE with Level=2 -> all outputs take reset values at once, and no Start follows after release.
REQ-037 With OPCODE_FILTER_EN defined, push 8'h48 then 8'h01 -> Illegal pulses once, the only Start carries 8'h01, IssueCount=1; with the macro undefined, both opcodes are issued.
